// File: rtl/myo_spi_responder.sv
// rtl/myo_spi_responder.sv - myocontrol SPI responder emulating one motor board; optional MYO_SPI_RESPONDER_CHECKSUM_EN
module myo_spi_responder #(
  parameter int unsigned FRAME_WORDS = 6,
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [15:0] HEADER_WORD = 16'h8000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        sck,
  input  logic        ss_n,
  input  logic        mosi,
  output logic        miso,
  input  logic [31:0] position,
  input  logic [15:0] velocity,
  input  logic [15:0] current,
  input  logic [15:0] displacement,
  output logic [15:0] pwm_ref,
  output logic        pwm_valid,
  output logic        frame_error,
  output logic        busy
);

`ifdef MYO_SPI_RESPONDER_CHECKSUM_EN
  localparam int unsigned FRAME_LEN = FRAME_WORDS + 1;
`else
  localparam int unsigned FRAME_LEN = FRAME_WORDS;
`endif

  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
  logic [SYNC_STAGES-1:0] ss_sync_q, ss_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic sck_prev_q, sck_prev_d;
  logic ss_prev_q, ss_prev_d;

  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [3:0]  word_cnt_q, word_cnt_d;
  logic [14:0] rx_sr_q, rx_sr_d;
  logic [15:0] rx_word0_q, rx_word0_d;
  logic [14:0] tx_sr_q, tx_sr_d;
  logic        miso_q, miso_d;
  logic [31:0] pos_q, pos_d;
  logic [15:0] vel_q, vel_d;
  logic [15:0] cur_q, cur_d;
  logic [15:0] disp_q, disp_d;
  logic [15:0] pwm_ref_q, pwm_ref_d;
  logic        pwm_valid_q, pwm_valid_d;
  logic        frame_error_q, frame_error_d;
`ifdef MYO_SPI_RESPONDER_CHECKSUM_EN
  logic [15:0] rx_xor_q, rx_xor_d;
  logic [15:0] rx_chk_q, rx_chk_d;
  logic [15:0] tx_chk;
`endif

  logic        sck_s, ss_s, mosi_s;
  logic        sck_rise, sck_fall, ss_rise, ss_fall;
  logic [15:0] rx_word;
  logic [15:0] tx_next_word;
  logic        frame_ok;

  assign sck_s  = sck_sync_q[SYNC_STAGES-1];
  assign ss_s   = ss_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  assign sck_rise = sck_s & ~sck_prev_q;
  assign sck_fall = ~sck_s & sck_prev_q;
  assign ss_rise  = ss_s & ~ss_prev_q;
  assign ss_fall  = ~ss_s & ss_prev_q;

  assign rx_word = {rx_sr_q, mosi_s};

  // Shift the raw SPI pins into the system clock domain and keep one prior sample for edge detection
  always_comb begin
    sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], sck};
    ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0], ss_n};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    sck_prev_d  = sck_s;
    ss_prev_d   = ss_s;
  end

`ifdef MYO_SPI_RESPONDER_CHECKSUM_EN
  assign tx_chk = HEADER_WORD ^ pos_q[31:16] ^ pos_q[15:0] ^ vel_q ^ cur_q ^ disp_q;
`endif

  // Pick the TX word for the next word slot from the frozen status snapshot
  always_comb begin
    tx_next_word = 16'h0000;
    if ({1'b0, word_cnt_q} < 5'(FRAME_WORDS)) begin
      case (word_cnt_q)
        4'd0:    tx_next_word = HEADER_WORD;
        4'd1:    tx_next_word = pos_q[31:16];
        4'd2:    tx_next_word = pos_q[15:0];
        4'd3:    tx_next_word = vel_q;
        4'd4:    tx_next_word = cur_q;
        4'd5:    tx_next_word = disp_q;
        default: tx_next_word = 16'h0000;
      endcase
    end
`ifdef MYO_SPI_RESPONDER_CHECKSUM_EN
    else if ({1'b0, word_cnt_q} == 5'(FRAME_WORDS)) begin
      tx_next_word = tx_chk;
    end
`endif
  end

  // A frame is good only when it ends exactly on a word boundary after the expected word count
  always_comb begin
    frame_ok = ({1'b0, word_cnt_q} == 5'(FRAME_LEN)) && (bit_cnt_q == 4'd0);
`ifdef MYO_SPI_RESPONDER_CHECKSUM_EN
    frame_ok = frame_ok && (rx_chk_q == rx_xor_q);
`endif
  end

  // Frame FSM: select starts a frame, sck edges shift data, deselect judges the frame
  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    word_cnt_d    = word_cnt_q;
    rx_sr_d       = rx_sr_q;
    rx_word0_d    = rx_word0_q;
    tx_sr_d       = tx_sr_q;
    miso_d        = miso_q;
    pos_d         = pos_q;
    vel_d         = vel_q;
    cur_d         = cur_q;
    disp_d        = disp_q;
    pwm_ref_d     = pwm_ref_q;
    pwm_valid_d   = 1'b0;
    frame_error_d = 1'b0;
`ifdef MYO_SPI_RESPONDER_CHECKSUM_EN
    rx_xor_d      = rx_xor_q;
    rx_chk_d      = rx_chk_q;
`endif
    case (state_q)
      S_IDLE: begin
        miso_d = 1'b0;
        if (ss_fall) begin
          pos_d      = position;
          vel_d      = velocity;
          cur_d      = current;
          disp_d     = displacement;
          tx_sr_d    = HEADER_WORD[14:0];
          miso_d     = HEADER_WORD[15];
          bit_cnt_d  = 4'd0;
          word_cnt_d = 4'd0;
          rx_sr_d    = 15'd0;
`ifdef MYO_SPI_RESPONDER_CHECKSUM_EN
          rx_xor_d   = 16'h0000;
          rx_chk_d   = 16'h0000;
`endif
          state_d    = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (ss_rise) begin
          if (frame_ok) begin
            pwm_ref_d   = rx_word0_q;
            pwm_valid_d = 1'b1;
          end else begin
            frame_error_d = 1'b1;
          end
          miso_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          if (sck_rise) begin
            rx_sr_d   = rx_word[14:0];
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd15) begin
              if (word_cnt_q == 4'd0) begin
                rx_word0_d = rx_word;
              end
`ifdef MYO_SPI_RESPONDER_CHECKSUM_EN
              if ({1'b0, word_cnt_q} < 5'(FRAME_WORDS)) begin
                rx_xor_d = rx_xor_q ^ rx_word;
              end else if ({1'b0, word_cnt_q} == 5'(FRAME_WORDS)) begin
                rx_chk_d = rx_word;
              end
`endif
              if (word_cnt_q != 4'd15) begin
                word_cnt_d = word_cnt_q + 4'd1;
              end
            end
          end
          if (sck_fall) begin
            if (bit_cnt_q == 4'd0) begin
              tx_sr_d = tx_next_word[14:0];
              miso_d  = tx_next_word[15];
            end else begin
              tx_sr_d = {tx_sr_q[13:0], 1'b0};
              miso_d  = tx_sr_q[14];
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; select synchroniser resets low so a frame open at reset release is skipped
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= S_IDLE;
      sck_sync_q    <= '0;
      ss_sync_q     <= '0;
      mosi_sync_q   <= '0;
      sck_prev_q    <= 1'b0;
      ss_prev_q     <= 1'b0;
      bit_cnt_q     <= 4'd0;
      word_cnt_q    <= 4'd0;
      rx_sr_q       <= 15'd0;
      rx_word0_q    <= 16'h0000;
      tx_sr_q       <= 15'd0;
      miso_q        <= 1'b0;
      pos_q         <= 32'h0;
      vel_q         <= 16'h0000;
      cur_q         <= 16'h0000;
      disp_q        <= 16'h0000;
      pwm_ref_q     <= 16'h0000;
      pwm_valid_q   <= 1'b0;
      frame_error_q <= 1'b0;
`ifdef MYO_SPI_RESPONDER_CHECKSUM_EN
      rx_xor_q      <= 16'h0000;
      rx_chk_q      <= 16'h0000;
`endif
    end else begin
      state_q       <= state_d;
      sck_sync_q    <= sck_sync_d;
      ss_sync_q     <= ss_sync_d;
      mosi_sync_q   <= mosi_sync_d;
      sck_prev_q    <= sck_prev_d;
      ss_prev_q     <= ss_prev_d;
      bit_cnt_q     <= bit_cnt_d;
      word_cnt_q    <= word_cnt_d;
      rx_sr_q       <= rx_sr_d;
      rx_word0_q    <= rx_word0_d;
      tx_sr_q       <= tx_sr_d;
      miso_q        <= miso_d;
      pos_q         <= pos_d;
      vel_q         <= vel_d;
      cur_q         <= cur_d;
      disp_q        <= disp_d;
      pwm_ref_q     <= pwm_ref_d;
      pwm_valid_q   <= pwm_valid_d;
      frame_error_q <= frame_error_d;
`ifdef MYO_SPI_RESPONDER_CHECKSUM_EN
      rx_xor_q      <= rx_xor_d;
      rx_chk_q      <= rx_chk_d;
`endif
    end
  end

  assign miso        = miso_q;
  assign pwm_ref     = pwm_ref_q;
  assign pwm_valid   = pwm_valid_q;
  assign frame_error = frame_error_q;
  assign busy        = (state_q == S_SHIFT);

endmodule

// File: tb/tb_myo_spi_responder.sv
// tb/tb_myo_spi_responder.sv - directed scoreboard bench for myo_spi_responder
module tb_myo_spi_responder;

  localparam int FW = 6;
`ifdef MYO_SPI_RESPONDER_CHECKSUM_EN
  localparam int FL = FW + 1;
`else
  localparam int FL = FW;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        sck = 1'b0;
  logic        ss_n = 1'b1;
  logic        mosi = 1'b0;
  logic        miso;
  logic [31:0] position = 32'h0;
  logic [15:0] velocity = 16'h0;
  logic [15:0] current = 16'h0;
  logic [15:0] displacement = 16'h0;
  logic [15:0] pwm_ref;
  logic        pwm_valid;
  logic        frame_error;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;
  int valid_cnt = 0;
  int err_cnt = 0;
  int v0, e0;

  logic [15:0] tx_w [16];
  logic [15:0] exp_q [$];
  logic [31:0] sp;
  logic [15:0] sv, sc, sd;
  logic [15:0] got;

  myo_spi_responder dut (
    .clock(clock), .reset(reset), .sck(sck), .ss_n(ss_n), .mosi(mosi), .miso(miso),
    .position(position), .velocity(velocity), .current(current), .displacement(displacement),
    .pwm_ref(pwm_ref), .pwm_valid(pwm_valid), .frame_error(frame_error), .busy(busy)
  );

  always #5 clock = ~clock;

  // count cycles each pulse output is high
  always @(negedge clock) begin
    if (pwm_valid === 1'b1) valid_cnt = valid_cnt + 1;
    if (frame_error === 1'b1) err_cnt = err_cnt + 1;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    assert (obs === exp) else begin
      n_bad = n_bad + 1;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  function automatic logic [15:0] model_tx(input int i);
    logic [15:0] w [6];
    w = '{16'h8000, sp[31:16], sp[15:0], sv, sc, sd};
    if (i < 6) return w[i];
`ifdef MYO_SPI_RESPONDER_CHECKSUM_EN
    if (i == FW) return w[0] ^ w[1] ^ w[2] ^ w[3] ^ w[4] ^ w[5];
`endif
    return 16'h0000;
  endfunction

  task automatic set_words(input logic [15:0] w0);
    tx_w[0] = w0;
    for (int i = 1; i < 16; i++) tx_w[i] = 16'($urandom);
`ifdef MYO_SPI_RESPONDER_CHECKSUM_EN
    tx_w[FW] = 16'h0000;
    for (int i = 0; i < FW; i++) tx_w[FW] = tx_w[FW] ^ tx_w[i];
`endif
  endtask

  task automatic spi_bits(input logic [15:0] w, input int nb, output logic [15:0] g);
    g = 16'h0000;
    for (int b = 0; b < nb; b++) begin
      mosi = w[15-b];
      tick(5);
      g = {g[14:0], miso};
      sck = 1'b1;
      tick(5);
      sck = 1'b0;
    end
  endtask

  task automatic spi_desel();
    tick(5);
    ss_n = 1'b1;
    tick(10);
  endtask

  task automatic run_frame(input int nw, input int xbits, input logic chg_pos);
    logic [15:0] g;
    logic [15:0] e;
    sp = position; sv = velocity; sc = current; sd = displacement;
    for (int i = 0; i < nw; i++) exp_q.push_back(model_tx(i));
    ss_n = 1'b0;
    tick(6);
    check("busy_in_frame", 32'(busy), 32'd1);
    for (int i = 0; i < nw; i++) begin
      spi_bits(tx_w[i], 16, g);
      e = exp_q.pop_front();
      check($sformatf("miso_word%0d", i), 32'(g), 32'(e));
      if (chg_pos && i == 0) position = 32'h0;
    end
    if (xbits > 0) spi_bits(tx_w[nw], xbits, g);
    spi_desel();
  endtask

  initial begin
    tick(4);
    reset = 1'b0;
    tick(4);
    check("rst_miso", 32'(miso), 32'd0);
    check("rst_pwm_ref", 32'(pwm_ref), 32'd0);
    check("rst_pwm_valid", 32'(pwm_valid), 32'd0);
    check("rst_frame_error", 32'(frame_error), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);

    // full frame, position changed after snapshot
    position = 32'hDEADBEEF; velocity = 16'hFEDC; current = 16'h1357; displacement = 16'h2468;
    set_words(16'h0123);
    v0 = valid_cnt; e0 = err_cnt;
    run_frame(FL, 0, 1'b1);
    check("f1_pwm_ref", 32'(pwm_ref), 32'h0123);
    check("f1_valid", 32'(valid_cnt - v0), 32'd1);
    check("f1_err", 32'(err_cnt - e0), 32'd0);
    check("f1_busy", 32'(busy), 32'd0);
    check("f1_miso", 32'(miso), 32'd0);

    // short frame of 3 words
    position = 32'h00010002; velocity = 16'h7FFF; current = 16'h0001; displacement = 16'hFFFF;
    set_words(16'hAAAA);
    v0 = valid_cnt; e0 = err_cnt;
    run_frame(3, 0, 1'b0);
    check("f2_err", 32'(err_cnt - e0), 32'd1);
    check("f2_valid", 32'(valid_cnt - v0), 32'd0);
    check("f2_pwm_ref_held", 32'(pwm_ref), 32'h0123);

    set_words(16'hFF00);
    v0 = valid_cnt; e0 = err_cnt;
    run_frame(FL, 0, 1'b0);
    check("f3_pwm_ref", 32'(pwm_ref), 32'hFF00);
    check("f3_valid", 32'(valid_cnt - v0), 32'd1);
    check("f3_err", 32'(err_cnt - e0), 32'd0);

    // 5 words + 7 bits
    set_words(16'h1111);
    v0 = valid_cnt; e0 = err_cnt;
    run_frame(5, 7, 1'b0);
    check("f4_err", 32'(err_cnt - e0), 32'd1);
    check("f4_valid", 32'(valid_cnt - v0), 32'd0);
    check("f4_pwm_ref_held", 32'(pwm_ref), 32'hFF00);

    // overlong frame: trailing words read as zero
    position = 32'h12345678; velocity = 16'h8001; current = 16'hC0DE; displacement = 16'h0F0F;
    set_words(16'h2222);
    v0 = valid_cnt; e0 = err_cnt;
    run_frame(FW + 2, 0, 1'b0);
    check("f5_err", 32'(err_cnt - e0), 32'd1);
    check("f5_valid", 32'(valid_cnt - v0), 32'd0);
    check("f5_pwm_ref_held", 32'(pwm_ref), 32'hFF00);

    // reset during word 2, then a frame opened while in reset
    set_words(16'h3333);
    v0 = valid_cnt; e0 = err_cnt;
    ss_n = 1'b0;
    tick(6);
    spi_bits(tx_w[0], 16, got);
    spi_bits(tx_w[1], 16, got);
    spi_bits(tx_w[2], 5, got);
    reset = 1'b1;
    tick(2);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_miso", 32'(miso), 32'd0);
    ss_n = 1'b1;
    tick(6);
    ss_n = 1'b0;
    tick(6);
    reset = 1'b0;
    tick(4);
    set_words(16'hBAD0);
    for (int i = 0; i < FL; i++) begin
      spi_bits(tx_w[i], 16, got);
      if (i == 1) check("stale_busy", 32'(busy), 32'd0);
    end
    spi_desel();
    check("stale_valid", 32'(valid_cnt - v0), 32'd0);
    check("stale_err", 32'(err_cnt - e0), 32'd0);
    check("stale_pwm_ref", 32'(pwm_ref), 32'd0);

    set_words(16'h5A5A);
    v0 = valid_cnt; e0 = err_cnt;
    run_frame(FL, 0, 1'b0);
    check("f7_pwm_ref", 32'(pwm_ref), 32'h5A5A);
    check("f7_valid", 32'(valid_cnt - v0), 32'd1);
    check("f7_err", 32'(err_cnt - e0), 32'd0);

`ifdef MYO_SPI_RESPONDER_CHECKSUM_EN
    set_words(16'h0F0F);
    v0 = valid_cnt; e0 = err_cnt;
    run_frame(FL, 0, 1'b0);
    check("ck_good_valid", 32'(valid_cnt - v0), 32'd1);
    check("ck_good_pwm_ref", 32'(pwm_ref), 32'h0F0F);
    tx_w[0] = 16'h7001;
    tx_w[FW] = 16'h0000;
    for (int i = 0; i < FW; i++) tx_w[FW] = tx_w[FW] ^ tx_w[i];
    tx_w[FW] = tx_w[FW] ^ 16'h0001;
    v0 = valid_cnt; e0 = err_cnt;
    run_frame(FL, 0, 1'b0);
    check("ck_bad_err", 32'(err_cnt - e0), 32'd1);
    check("ck_bad_valid", 32'(valid_cnt - v0), 32'd0);
    check("ck_bad_pwm_ref", 32'(pwm_ref), 32'h0F0F);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
